ifu_fetch_buffer: RTL and testbench

- Fetch stage directly downstream of the PC register. Consumes the current PC, issues word reads to the instruction memory, and queues returned instructions with their PC tags.
- Presents instructions to decode over a valid/ready handshake.
- Drives pc_adv back upstream so the PC register only advances when a fetch is actually issued.
- Handles redirects (branch/jump/reset vector) by flushing all queued and in-flight fetches.

---
 rtl/ifu_fetch_buffer_pkg.sv | 16 +
 rtl/ifu_fetch_buffer_if.sv | 36 +++
 rtl/ifu_fetch_buffer_fetch_fifo.sv | 82 ++++++++
 rtl/ifu_fetch_buffer.sv | 84 ++++++++
 tb/tb_ifu_fetch_buffer.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_buffer_pkg.sv
// Shared fetch-stage definitions: reset vector, instruction width, default
// instruction-memory address width and the queue entry layout.
package ifu_fetch_buffer_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam int          INSTR_W   = 32;
    localparam int          IMEM_AW   = 10;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // One queued fetch: the PC it was fetched from and the returned word.
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_buffer_if.sv
// Fetch-stage bundle: PC register link, instruction-memory port and the
// decode-side handshake.
//
// Decode handshake: an entry moves on every rising edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready, and while
// out_valid=1 with out_ready=0 the head (out_pc/out_instr) holds stable.
interface ifu_fetch_buffer_if
    import ifu_fetch_buffer_pkg::*;
#(
    parameter int IM_AW = IMEM_AW,
    parameter int PTR_W = 2
);
    logic [31:0]        pc;
    logic               pc_adv;
    logic               flush;
    logic               im_req;
    logic [IM_AW-1:0]   im_addr;
    logic [INSTR_W-1:0] im_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [31:0]        out_pc;
    logic [PTR_W:0]     count;

    // Fetch buffer side.
    modport master (
        input  pc, flush, im_rdata, out_ready,
        output pc_adv, im_req, im_addr, out_valid, out_instr, out_pc, count
    );

    // Surrounding pipeline / memory side.
    modport slave (
        output pc, flush, im_rdata, out_ready,
        input  pc_adv, im_req, im_addr, out_valid, out_instr, out_pc, count
    );
endinterface

// File: rtl/ifu_fetch_buffer_fetch_fifo.sv
// DEPTH-entry circular queue of {pc, instr} with flush, head read straight
// from storage and an occupancy count of 0..DEPTH.
module ifu_fetch_buffer_fetch_fifo
    import ifu_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           push,
    input  fetch_entry_t   push_entry,
    input  logic           pop,
    output fetch_entry_t   head,
    output logic [PTR_W:0] count
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_pop;

    // Next-state: flush wins over everything; pointers wrap naturally at DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop & (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; storage is cleared so the head reads as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: 32'h0, instr: NOP_INSTR};
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // A push into a full queue with no pop in the same cycle would overwrite
    // the head; the issue logic upstream reserves space so this must not happen.
    property p_no_overflow;
        @(posedge clk) disable iff (!rst_n)
            !(push && !flush && !do_pop && (count_q == FULL_CNT));
    endproperty
    a_no_overflow: assert property (p_no_overflow);

endmodule

// File: rtl/ifu_fetch_buffer.sv
// Fetch stage: issues one instruction-memory read per cycle while the queue
// has a reserved slot, tags each returned word with its PC and hands entries
// to decode. pc_adv tells the PC register a fetch actually went out.
module ifu_fetch_buffer
    import ifu_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int IM_AW = IMEM_AW
) (
    input  logic               clk,
    input  logic               reset,
    ifu_fetch_buffer_if.master bus
);
    localparam logic [PTR_W+1:0] DEPTH_OCC = (PTR_W+2)'(DEPTH);

    logic             inflight_q, inflight_d;
    logic [31:0]      pc_q, pc_d;
    logic             issue;
    logic [PTR_W+1:0] occupancy;
    logic [PTR_W:0]   fifo_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_valid;

    // Issue only when queued entries plus the outstanding fetch leave a free
    // slot, so the returning word always has somewhere to land.
    always_comb begin
        occupancy = {1'b0, fifo_count} + {{(PTR_W+1){1'b0}}, inflight_q};
        issue     = reset & ~bus.flush & (occupancy < DEPTH_OCC);
    end

    // Remember the issued PC; memory answers exactly one cycle later.
    always_comb begin
        inflight_d = issue;
        pc_d       = issue ? bus.pc : pc_q;
    end

    // Outstanding-fetch tracking registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q <= 1'b0;
            pc_q       <= 32'h0;
        end else begin
            inflight_q <= inflight_d;
            pc_q       <= pc_d;
        end
    end

    // The response is pushed on the edge after the request; a flush in that
    // cycle drops it inside the queue.
    always_comb begin
        fifo_push        = inflight_q;
        push_entry.pc    = pc_q;
        push_entry.instr = bus.im_rdata;
        fifo_valid       = (fifo_count != '0);
        fifo_pop         = fifo_valid & bus.out_ready;
    end

    ifu_fetch_buffer_fetch_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .flush      (bus.flush),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head_entry),
        .count      (fifo_count)
    );

    assign bus.im_req    = issue;
    assign bus.pc_adv    = issue;
    assign bus.im_addr   = bus.pc[IM_AW+1:2];
    assign bus.out_valid = fifo_valid;
    assign bus.out_instr = head_entry.instr;
    assign bus.out_pc    = head_entry.pc;
    assign bus.count     = fifo_count;

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// Self-checking bench for ifu_fetch_buffer. The environment plays PC register
// and one-cycle instruction memory (word = fetched PC ^ salt); a queue model
// of the fetch stage predicts every cycle's outputs.
module tb_ifu_fetch_buffer;
    import ifu_fetch_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int IM_AW = 10;

    logic clk;
    logic reset;

    ifu_fetch_buffer_if #(.IM_AW(IM_AW), .PTR_W(PTR_W)) bus ();

    ifu_fetch_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .IM_AW(IM_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- model and scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];        // expected queue contents {pc, instr}
    int          m_inflight;
    logic [31:0] m_pc;
    logic [31:0] salt;
    logic [31:0] act_pc_q[$];     // heads actually handed to decode
    logic [31:0] act_instr_q[$];

    // Values sampled just before an edge, and the model's prediction.
    logic             s_valid, s_im_req, s_pc_adv;
    logic [PTR_W:0]   s_count;
    logic [IM_AW-1:0] s_im_addr;
    logic [31:0]      s_out_pc, s_out_instr;
    logic             e_valid, e_im_req;
    logic [PTR_W:0]   e_count;
    logic [IM_AW-1:0] e_im_addr;
    logic [63:0]      e_head;

    // ---------------- driver tasks ----------------
    task automatic clear_model();
        exp_q.delete();
        m_inflight = 0;
        m_pc       = 32'h0;
        act_pc_q.delete();
        act_instr_q.delete();
    endtask

    // One clock: sample/predict at the falling edge, then advance model,
    // memory and PC register after the rising edge.
    task automatic step();
        logic [31:0] fire_pc;
        @(negedge clk);
        s_valid     = bus.out_valid;
        s_count     = bus.count;
        s_im_req    = bus.im_req;
        s_pc_adv    = bus.pc_adv;
        s_im_addr   = bus.im_addr;
        s_out_pc    = bus.out_pc;
        s_out_instr = bus.out_instr;
        e_count     = (PTR_W+1)'(exp_q.size());
        e_valid     = (exp_q.size() != 0);
        e_im_req    = reset && !bus.flush && ((exp_q.size() + m_inflight) < DEPTH);
        e_im_addr   = bus.pc[IM_AW+1:2];
        e_head      = e_valid ? exp_q[0] : 64'd0;
        fire_pc     = bus.pc;
        @(posedge clk);
        if (!reset || bus.flush) begin
            exp_q.delete();
            m_inflight = 0;
        end else begin
            if (s_valid && bus.out_ready) begin
                act_pc_q.push_back(s_out_pc);
                act_instr_q.push_back(s_out_instr);
            end
            if (e_valid && bus.out_ready) void'(exp_q.pop_front());
            if (m_inflight != 0) exp_q.push_back({m_pc, m_pc ^ salt});
            m_inflight = e_im_req ? 1 : 0;
            m_pc       = fire_pc;
        end
        #1;
        bus.im_rdata = s_im_req ? (fire_pc ^ salt) : $urandom();
        if (s_pc_adv) bus.pc = bus.pc + 32'd4;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.pc        = PC_RESET;
        salt          = $urandom();
        clear_model();
        step();
        step();
        reset = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset         = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.pc        = PC_RESET;
        bus.im_rdata  = $urandom();
        salt          = 32'h0;
        clear_model();
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({s_valid, s_count, s_im_req, s_pc_adv, s_out_pc, s_out_instr} !== '0) begin
                errors++;
                $display("FAIL reset_state k=%0d got valid=%b count=%0d req=%b adv=%b pc=%h instr=%h, need all zero",
                         k, s_valid, s_count, s_im_req, s_pc_adv, s_out_pc, s_out_instr);
            end
        end
    endtask

    task automatic test_stream();
        int first = -1;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            if (s_valid && first < 0) first = k;
            checks++;
            if ({s_valid, s_count, s_im_req, s_pc_adv, s_im_addr} !== {e_valid, e_count, e_im_req, e_im_req, e_im_addr}) begin
                errors++;
                $display("FAIL stream_ctrl k=%0d got v/c/req/adv/addr %b/%0d/%b/%b/%h need %b/%0d/%b/%b/%h", k,
                         s_valid, s_count, s_im_req, s_pc_adv, s_im_addr, e_valid, e_count, e_im_req, e_im_req, e_im_addr);
            end
        end
        checks++;
        if (first != 2) begin
            errors++;
            $display("FAIL stream_first_valid got edge %0d need edge 2", first);
        end
        checks++;
        if (act_pc_q.size() != 14) begin
            errors++;
            $display("FAIL stream_throughput got %0d pops need 14", act_pc_q.size());
        end
        foreach (act_pc_q[i]) begin
            checks++;
            if (act_pc_q[i] !== PC_RESET + 32'(4 * i) || act_instr_q[i] !== PC_RESET + 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_order i=%0d got pc=%h instr=%h need %h", i, act_pc_q[i], act_instr_q[i],
                         PC_RESET + 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        int issued = 0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step();
            if (s_im_req) issued++;
            checks++;
            if ({s_valid, s_count, s_im_req, s_pc_adv} !== {e_valid, e_count, e_im_req, e_im_req}) begin
                errors++;
                $display("FAIL fill_ctrl k=%0d got v/c/req/adv %b/%0d/%b/%b need %b/%0d/%b/%b", k,
                         s_valid, s_count, s_im_req, s_pc_adv, e_valid, e_count, e_im_req, e_im_req);
            end
        end
        checks++;
        if (issued != 4) begin
            errors++;
            $display("FAIL fill_issued got %0d fetches need 4", issued);
        end
        step();
        checks++;
        if (s_count !== 3'd4 || s_im_req !== 1'b0 || s_pc_adv !== 1'b0 || s_out_pc !== PC_RESET ||
            s_out_instr !== (PC_RESET ^ salt) || bus.pc !== PC_RESET + 32'h10) begin
            errors++;
            $display("FAIL fill_full got count=%0d req=%b adv=%b head=%h pc=%h need 4/0/0/%h/%h", s_count, s_im_req,
                     s_pc_adv, s_out_pc, bus.pc, PC_RESET, PC_RESET + 32'h10);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (e_valid) begin
                checks++;
                if ({s_out_pc, s_out_instr} !== e_head) begin
                    errors++;
                    $display("FAIL drain_head k=%0d got %h/%h need %h", k, s_out_pc, s_out_instr, e_head);
                end
            end
        end
        checks++;
        if (act_pc_q.size() != 12) begin
            errors++;
            $display("FAIL drain_count got %0d pops need 12", act_pc_q.size());
        end
        foreach (act_pc_q[i]) begin
            checks++;
            if (act_pc_q[i] !== PC_RESET + 32'(4 * i) || act_instr_q[i] !== ((PC_RESET + 32'(4 * i)) ^ salt)) begin
                errors++;
                $display("FAIL drain_order i=%0d got pc=%h instr=%h need pc=%h", i, act_pc_q[i], act_instr_q[i],
                         PC_RESET + 32'(4 * i));
            end
        end
    endtask

    task automatic test_simul_push_pop();
        do_reset();
        repeat (4) step();
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (s_count !== 3'd3 || s_im_req !== 1'b0 || s_valid !== 1'b1) begin
            errors++;
            $display("FAIL pushpop_reserve got count=%0d req=%b valid=%b need 3/0/1", s_count, s_im_req, s_valid);
        end
        step();
        checks++;
        if (s_count !== 3'd3 || s_im_req !== 1'b1) begin
            errors++;
            $display("FAIL pushpop_after got count=%0d req=%b need 3/1", s_count, s_im_req);
        end
        checks++;
        if ({s_out_pc, s_out_instr} !== e_head) begin
            errors++;
            $display("FAIL pushpop_head got %h/%h need %h", s_out_pc, s_out_instr, e_head);
        end
    endtask

    task automatic test_flush();
        logic [31:0] new_pc = 32'h0000_3100;
        do_reset();
        repeat (3) step();
        bus.flush = 1'b1;
        bus.pc    = new_pc;
        step();
        checks++;
        if (s_im_req !== 1'b0 || s_pc_adv !== 1'b0 || s_count !== 3'd2) begin
            errors++;
            $display("FAIL flush_cycle got req=%b adv=%b count=%0d need 0/0/2", s_im_req, s_pc_adv, s_count);
        end
        bus.flush = 1'b0;
        step();
        checks++;
        if (s_count !== 3'd0 || s_valid !== 1'b0 || s_im_req !== 1'b1 || s_im_addr !== new_pc[IM_AW+1:2]) begin
            errors++;
            $display("FAIL flush_after got count=%0d valid=%b req=%b addr=%h need 0/0/1/%h", s_count, s_valid,
                     s_im_req, s_im_addr, new_pc[IM_AW+1:2]);
        end
        bus.out_ready = 1'b1;
        repeat (6) step();
        checks++;
        if (act_pc_q.size() == 0 || act_pc_q[0] !== new_pc || act_instr_q[0] !== (new_pc ^ salt)) begin
            errors++;
            $display("FAIL flush_redirect got first pc=%h need %h", (act_pc_q.size() != 0) ? act_pc_q[0] : 32'hx, new_pc);
        end
        foreach (act_pc_q[i]) begin
            checks++;
            if (act_pc_q[i] === 32'h0000_3008) begin
                errors++;
                $display("FAIL flush_dropped got pc=%h at pop %0d need it discarded", act_pc_q[i], i);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (4) step();
        checks++;
        if (bus.count !== 3'd3) begin
            errors++;
            $display("FAIL areset_pre got count=%0d need 3", bus.count);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.im_req !== 1'b0 || bus.pc_adv !== 1'b0) begin
            errors++;
            $display("FAIL areset_now got valid=%b count=%0d req=%b adv=%b need all 0", bus.out_valid, bus.count,
                     bus.im_req, bus.pc_adv);
        end
        clear_model();
        step();
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int   k = 0;
        do_reset();
        while (act_pc_q.size() < 20 && k < 200) begin
            bus.out_ready = pat[k % 5];
            step();
            k++;
            checks++;
            if ({s_valid, s_count, s_im_req} !== {e_valid, e_count, e_im_req}) begin
                errors++;
                $display("FAIL wrap_ctrl k=%0d got v/c/req %b/%0d/%b need %b/%0d/%b", k, s_valid, s_count, s_im_req,
                         e_valid, e_count, e_im_req);
            end
        end
        checks++;
        if (act_pc_q.size() < 20) begin
            errors++;
            $display("FAIL wrap_timeout got %0d pops need 20", act_pc_q.size());
        end
        for (int i = 0; i < 20 && i < act_pc_q.size(); i++) begin
            checks++;
            if (act_pc_q[i] !== PC_RESET + 32'(4 * i) || act_instr_q[i] !== ((PC_RESET + 32'(4 * i)) ^ salt)) begin
                errors++;
                $display("FAIL wrap_order i=%0d got pc=%h instr=%h need pc=%h", i, act_pc_q[i], act_instr_q[i],
                         PC_RESET + 32'(4 * i));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            if (bus.flush) bus.pc = $urandom();
            step();
            bus.flush = 1'b0;
            checks++;
            if ({s_valid, s_count, s_im_req, s_pc_adv, s_im_addr} !== {e_valid, e_count, e_im_req, e_im_req, e_im_addr}) begin
                errors++;
                $display("FAIL rand_ctrl k=%0d got v/c/req/adv/addr %b/%0d/%b/%b/%h need %b/%0d/%b/%b/%h", k,
                         s_valid, s_count, s_im_req, s_pc_adv, s_im_addr, e_valid, e_count, e_im_req, e_im_req, e_im_addr);
            end
            if (e_valid) begin
                checks++;
                if ({s_out_pc, s_out_instr} !== e_head) begin
                    errors++;
                    $display("FAIL rand_head k=%0d got %h/%h need %h", k, s_out_pc, s_out_instr, e_head);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_simul_push_pop();
        test_flush();
        test_async_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
